peripheral_hub: RTL

PERIPHERAL_HUB -- requirements
Module: peripheral_hub

---
 rtl/peripheral_hub.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/peripheral_hub.sv
// Memory-mapped peripheral hub: reloadable timer with level interrupt, LED register,
// free-running cycle counter and a multiplexed 7-segment display scanner.
module peripheral_hub #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
  parameter int          LED_WIDTH    = 8,
  parameter int          DIGIT_COUNT  = 4,
  parameter logic [15:0] SCAN_DIVIDER = 16'd50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            i_address,
  input  logic                   i_control_read,
  input  logic                   i_control_write,
  input  logic [31:0]            i_control_write_data,
  output logic [31:0]            o_control_read_data,
  output logic [LED_WIDTH-1:0]   o_led,
  output logic [DIGIT_COUNT-1:0] o_digit_select,
  output logic [7:0]             o_segment,
  output logic                   o_irq
);

  localparam logic [31:0] OFF_TH   = 32'h0000_0000;
  localparam logic [31:0] OFF_TL   = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON = 32'h0000_0008;
  localparam logic [31:0] OFF_LED  = 32'h0000_000C;
  localparam logic [31:0] OFF_DIG  = 32'h0000_0010;
  localparam logic [31:0] OFF_CNT  = 32'h0000_0014;

  // Decimal-point bits sit in the top DIGIT_COUNT bits only when they clear the nibbles.
  localparam bit DP_FITS = ((5 * DIGIT_COUNT) <= 32);
  localparam int DP_BASE = DP_FITS ? (32 - DIGIT_COUNT) : 0;

  function automatic logic [31:0] digital_mask();
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      mask[i] = (i < (4 * DIGIT_COUNT)) || (DP_FITS && (i >= DP_BASE));
    end
    return mask;
  endfunction

  localparam logic [31:0] DIGITAL_MASK = digital_mask();

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  function automatic logic [DIGIT_COUNT-1:0] select_n(input logic [2:0] idx);
    logic [DIGIT_COUNT-1:0] sel;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      sel[i] = (idx != 3'(i));
    end
    return sel;
  endfunction

  logic [31:0]            th_q, th_d, tl_q, tl_d, cnt_q, cnt_d, digital_q, digital_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic                   timer_en_q, timer_en_d, irq_en_q, irq_en_d;
  logic                   irq_status_q, irq_status_d, irq_q, irq_d;
  logic [15:0]            presc_q, presc_d;
  logic [2:0]             idx_q, idx_d;
  logic [DIGIT_COUNT-1:0] sel_q, sel_d;
  logic [7:0]             seg_q, seg_d;

  logic [31:0] offset, read_data, led_ext;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_dig, wr_cnt;
  logic        overflow, irq_set, presc_wrap;
  logic [3:0]  nibble;
  logic [4:0]  dp_pos;

  // Address decode and read mux; reads see register values from before any same-cycle write
  always_comb begin
    offset  = i_address - BASE_ADDRESS;
    wr_th   = i_control_write && (offset == OFF_TH);
    wr_tl   = i_control_write && (offset == OFF_TL);
    wr_tcon = i_control_write && (offset == OFF_TCON);
    wr_led  = i_control_write && (offset == OFF_LED);
    wr_dig  = i_control_write && (offset == OFF_DIG);
    wr_cnt  = i_control_write && (offset == OFF_CNT);
    led_ext = 32'h0000_0000;
    led_ext[LED_WIDTH-1:0] = led_q;
    read_data = 32'h0000_0000;
    if (i_control_read) begin
      case (offset)
        OFF_TH:   read_data = th_q;
        OFF_TL:   read_data = tl_q;
        OFF_TCON: read_data = {29'h0, irq_status_q, irq_en_q, timer_en_q};
        OFF_LED:  read_data = led_ext;
        OFF_DIG:  read_data = digital_q;
        OFF_CNT:  read_data = cnt_q;
        default:  read_data = 32'h0000_0000;
      endcase
    end else begin
      read_data = 32'h0000_0000;
    end
  end

  assign o_control_read_data = read_data;

  // Register, timer and interrupt next state; a TL write beats reload, an overflow beats W1C
  always_comb begin
    overflow = timer_en_q && (tl_q == 32'hFFFF_FFFF);
    irq_set  = overflow && irq_en_q && !wr_tl;
    th_d     = wr_th ? i_control_write_data : th_q;
    if (wr_tl) begin
      tl_d = i_control_write_data;
    end else if (overflow) begin
      tl_d = th_q;
    end else if (timer_en_q) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end
    timer_en_d = wr_tcon ? i_control_write_data[0] : timer_en_q;
    irq_en_d   = wr_tcon ? i_control_write_data[1] : irq_en_q;
    if (irq_set) begin
      irq_status_d = 1'b1;
    end else if (wr_tcon && i_control_write_data[2]) begin
      irq_status_d = 1'b0;
    end else begin
      irq_status_d = irq_status_q;
    end
    irq_d     = irq_status_d && irq_en_d;
    led_d     = wr_led ? i_control_write_data[LED_WIDTH-1:0] : led_q;
    digital_d = wr_dig ? (i_control_write_data & DIGITAL_MASK) : digital_q;
    cnt_d     = wr_cnt ? i_control_write_data : (cnt_q + 32'd1);
  end

  // Display scan; segments decode fresh DIGITAL data so writes show without waiting a scan slot
  always_comb begin
    presc_wrap = (presc_q == (SCAN_DIVIDER - 16'd1));
    presc_d    = presc_wrap ? 16'd0 : (presc_q + 16'd1);
    if (!presc_wrap) begin
      idx_d = idx_q;
    end else if (idx_q == 3'(DIGIT_COUNT - 1)) begin
      idx_d = 3'd0;
    end else begin
      idx_d = idx_q + 3'd1;
    end
    sel_d  = select_n(idx_d);
    nibble = digital_d[{idx_q, 2'b00} +: 4];
    dp_pos = 5'(DP_BASE) + {2'b00, idx_q};
    seg_d  = {(DP_FITS ? digital_d[dp_pos] : 1'b0), hex7(nibble)};
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q         <= 32'h0000_0000;
      tl_q         <= 32'h0000_0000;
      cnt_q        <= 32'h0000_0000;
      digital_q    <= 32'h0000_0000;
      led_q        <= '0;
      timer_en_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_status_q <= 1'b0;
      irq_q        <= 1'b0;
      presc_q      <= 16'd0;
      idx_q        <= 3'd0;
      sel_q        <= select_n(3'd0);
      seg_q        <= 8'h3F;
    end else begin
      th_q         <= th_d;
      tl_q         <= tl_d;
      cnt_q        <= cnt_d;
      digital_q    <= digital_d;
      led_q        <= led_d;
      timer_en_q   <= timer_en_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign o_led          = led_q;
  assign o_irq          = irq_q;
  assign o_digit_select = sel_q;
  assign o_segment      = seg_q;

endmodule
